seg_scan_rx: RTL and testbench

//  Receiver for the multiplexed 6-digit 7-segment scan bus (seg a..g, dp, active-low digit enables).

---
 rtl/seg_scan_pkg.sv | 26 ++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg_scan_rx.sv | 204 ++++++++++++++++++++
 tb/tb_seg_scan_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan receiver: segment codes, BCD markers, FSM states.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD   = 4'hE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment {a..g} pattern to BCD decoder; blank -> F, anything unrecognised -> E + bad.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       bad
);

  always_comb begin
    bcd = BCD_BAD;
    bad = 1'b1;
    case (seg)
      SEG_0:     begin bcd = 4'd0;      bad = 1'b0; end
      SEG_1:     begin bcd = 4'd1;      bad = 1'b0; end
      SEG_2:     begin bcd = 4'd2;      bad = 1'b0; end
      SEG_3:     begin bcd = 4'd3;      bad = 1'b0; end
      SEG_4:     begin bcd = 4'd4;      bad = 1'b0; end
      SEG_5:     begin bcd = 4'd5;      bad = 1'b0; end
      SEG_6:     begin bcd = 4'd6;      bad = 1'b0; end
      SEG_7:     begin bcd = 4'd7;      bad = 1'b0; end
      SEG_8:     begin bcd = 4'd8;      bad = 1'b0; end
      SEG_9:     begin bcd = 4'd9;      bad = 1'b0; end
      SEG_BLANK: begin bcd = BCD_BLANK; bad = 1'b0; end
      default:   begin bcd = BCD_BAD;   bad = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Scan-bus receiver: settles and captures each digit slot, publishes a frame once all slots are fresh.
// Frame pulse lands 2 + SETTLE_CYC + 2 clk after the last slot's enable edge at the pins.
module seg_scan_rx
  import seg_scan_pkg::*;
#(
  parameter int N_DIGIT     = 6,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             i_seg,
  input  logic                   i_seg_dp,
  input  logic [N_DIGIT-1:0]     i_seg_enb,
  output logic [7*N_DIGIT-1:0]   o_digit_seg,
  output logic [4*N_DIGIT-1:0]   o_digit_bcd,
  output logic [N_DIGIT-1:0]     o_dp,
  output logic                   o_frame_vld,
  output logic                   o_bad_code,
  output logic                   o_scan_err,
  output logic                   o_lost
);

  localparam int IW = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // {seg[6:0], dp} travels as one 8-bit pattern
  logic [7:0]         pat_meta, pat_sync;
  logic [N_DIGIT-1:0] enb_meta, enb_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_meta <= '0;
      pat_sync <= '0;
      enb_meta <= '1;
      enb_sync <= '1;
    end else begin
      pat_meta <= {i_seg, i_seg_dp};
      pat_sync <= pat_meta;
      enb_meta <= i_seg_enb;
      enb_sync <= enb_meta;
    end
  end

  logic [N_DIGIT-1:0] low;
  logic [IW-1:0]      idx;
  logic               idx_vld, multi, multi_q;

  always_comb begin
    low     = ~enb_sync;
    multi   = (low & (low - 1'b1)) != '0;
    idx_vld = (low != '0) && !multi;
    idx     = '0;
    for (int k = 0; k < N_DIGIT; k++) begin
      if (low[k]) idx = IW'(k);
    end
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cur_idx, last_idx;
  logic [7:0]    cur_pat;
  logic          load, inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE: begin
        if (idx_vld) begin
          state_nxt = SETTLE;
          load      = 1'b1;
        end
      end
      SETTLE: begin
        if (!idx_vld) begin
          state_nxt = IDLE;
        end else if (idx != cur_idx || pat_sync != cur_pat) begin
          load = 1'b1;
        end else if (cnt == CW'(SETTLE_CYC)) begin
          state_nxt = CAPTURE;
        end else begin
          inc = 1'b1;
        end
      end
      CAPTURE: state_nxt = HOLD;
      HOLD: begin
        // only a different slot re-arms; a lingering enable never captures twice
        if (!idx_vld) begin
          state_nxt = IDLE;
        end else if (idx != cur_idx) begin
          state_nxt = SETTLE;
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [3:0] cap_bcd;
  logic       cap_bad;

  seg7_to_bcd u_dec (
    .seg (cur_pat[7:1]),
    .bcd (cap_bcd),
    .bad (cap_bad)
  );

  logic                 cap, seq_err, frame, seq_free;
  logic [IW-1:0]        exp_idx;
  logic [N_DIGIT-1:0]   cap_bit, mask, mask_upd;
  logic [7*N_DIGIT-1:0] sh_seg, sh_seg_nxt;
  logic [4*N_DIGIT-1:0] sh_bcd, sh_bcd_nxt;
  logic [N_DIGIT-1:0]   sh_dp, sh_dp_nxt;
  logic [TW-1:0]        tcnt;

  always_comb begin
    cap        = (state == CAPTURE);
    exp_idx    = (last_idx == IW'(N_DIGIT - 1)) ? '0 : last_idx + 1'b1;
    seq_err    = cap && !seq_free && (cur_idx != exp_idx);
    cap_bit    = '0;
    sh_seg_nxt = sh_seg;
    sh_bcd_nxt = sh_bcd;
    sh_dp_nxt  = sh_dp;
    for (int k = 0; k < N_DIGIT; k++) begin
      if (cur_idx == IW'(k)) begin
        cap_bit[k]           = 1'b1;
        sh_seg_nxt[7*k +: 7] = cur_pat[7:1];
        sh_bcd_nxt[4*k +: 4] = cap_bcd;
        sh_dp_nxt[k]         = cur_pat[0];
      end
    end
    // an out-of-order slot restarts frame assembly from itself
    mask_upd = seq_err ? cap_bit : (mask | cap_bit);
    frame    = cap && (mask_upd == '1);
  end

  assign o_bad_code = cap && cap_bad;
  assign o_scan_err = (multi && !multi_q) || seq_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      cur_idx     <= '0;
      cur_pat     <= '0;
      last_idx    <= '0;
      multi_q     <= 1'b0;
      seq_free    <= 1'b1;
      mask        <= '0;
      tcnt        <= '0;
      sh_seg      <= '0;
      sh_bcd      <= '0;
      sh_dp       <= '0;
      o_digit_seg <= '0;
      o_digit_bcd <= '0;
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_lost      <= 1'b0;
    end else begin
      multi_q     <= multi;
      o_frame_vld <= frame;

      if (load) begin
        cnt     <= CW'(1);
        cur_idx <= idx;
        cur_pat <= pat_sync;
      end else if (inc) begin
        cnt <= cnt + 1'b1;
      end

      if (cap) begin
        sh_seg   <= sh_seg_nxt;
        sh_bcd   <= sh_bcd_nxt;
        sh_dp    <= sh_dp_nxt;
        last_idx <= cur_idx;
        seq_free <= frame;
        mask     <= frame ? '0 : mask_upd;
        tcnt     <= '0;
      end else if (tcnt != TW'(TIMEOUT_CYC)) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          o_lost   <= 1'b1;
          mask     <= '0;
          seq_free <= 1'b1;
        end
      end

      if (frame) begin
        o_digit_seg <= sh_seg_nxt;
        o_digit_bcd <= sh_bcd_nxt;
        o_dp        <= sh_dp_nxt;
        o_lost      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed + randomized scan sequences checked against a transaction-level model of frame assembly.
module tb_seg_scan_rx;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 3000;
  localparam int SLOT    = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic        dp = 1'b0;
  logic [5:0]  enb = '1;
  logic [41:0] digit_seg;
  logic [23:0] digit_bcd;
  logic [5:0]  dpo;
  logic        frame_vld, bad_code, scan_err, lost;

  seg_scan_rx #(.N_DIGIT(6), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_seg       (seg),
    .i_seg_dp    (dp),
    .i_seg_enb   (enb),
    .o_digit_seg (digit_seg),
    .o_digit_bcd (digit_bcd),
    .o_dp        (dpo),
    .o_frame_vld (frame_vld),
    .o_bad_code  (bad_code),
    .o_scan_err  (scan_err),
    .o_lost      (lost)
  );

  always #10 clk = ~clk;

  int   cyc = 0;
  int   frames = 0, errs_seen = 0, bads_seen = 0, last_frame_cyc = -1;
  logic lost_at_frame = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_vld) begin
      frames++;
      last_frame_cyc = cyc;
      lost_at_frame  = lost;
    end
    if (scan_err) errs_seen++;
    if (bad_code) bads_seen++;
  end

  logic [6:0] seg_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  // reference model state
  logic [6:0]  m_seg [6];
  logic        m_dp  [6];
  logic [5:0]  m_mask = '0;
  logic        m_free = 1'b1;
  int          m_last = 0;
  logic [41:0] exp_seg = '0;
  logic [23:0] exp_bcd = '0;
  logic [5:0]  exp_dp = '0;
  logic        exp_lost = 1'b0;
  int          exp_frames = 0, exp_errs = 0, exp_bads = 0;

  int checks = 0, errors = 0;
  int drv_cyc = 0;
  logic [6:0] pat_q [6];
  logic       dp_q  [6];

  function automatic logic [3:0] ref_dec(input logic [6:0] p);
    logic [3:0] r;
    r = 4'hE;
    if (p == 7'h00) r = 4'hF;
    for (int d = 0; d < 10; d++) if (seg_tbl[d] == p) r = 4'(d);
    return r;
  endfunction

  task automatic model_cap(input int idx, input logic [6:0] s, input logic d);
    if (!m_free && idx != (m_last + 1) % 6) begin
      exp_errs++;
      m_mask = '0;
    end
    m_mask[idx] = 1'b1;
    m_free      = 1'b0;
    m_last      = idx;
    m_seg[idx]  = s;
    m_dp[idx]   = d;
    if (ref_dec(s) == 4'hE) exp_bads++;
    if (m_mask == 6'h3F) begin
      for (int k = 0; k < 6; k++) begin
        exp_seg[7*k +: 7] = m_seg[k];
        exp_bcd[4*k +: 4] = ref_dec(m_seg[k]);
        exp_dp[k]         = m_dp[k];
      end
      exp_frames++;
      m_mask   = '0;
      m_free   = 1'b1;
      exp_lost = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk_int({tag, " frames"}, frames, exp_frames);
    chk_int({tag, " scan_err"}, errs_seen, exp_errs);
    chk_int({tag, " bad_code"}, bads_seen, exp_bads);
    chk_vec({tag, " digit_seg"}, 64'(digit_seg), 64'(exp_seg));
    chk_vec({tag, " digit_bcd"}, 64'(digit_bcd), 64'(exp_bcd));
    chk_vec({tag, " dp"}, 64'(dpo), 64'(exp_dp));
    chk_vec({tag, " lost"}, 64'(lost), 64'(exp_lost));
  endtask

  task automatic slot(input int idx, input logic [6:0] s, input logic d,
                      input int glitch, input logic [6:0] pre);
    enb      = '1;
    enb[idx] = 1'b0;
    dp       = d;
    drv_cyc  = cyc;
    if (glitch > 0) begin
      seg = pre;
      wait_cyc(glitch);
      seg = s;
      wait_cyc(SLOT - glitch);
    end else begin
      seg = s;
      wait_cyc(SLOT);
    end
    model_cap(idx, s, d);
    check_all($sformatf("slot%0d", idx));
  endtask

  task automatic scan();
    for (int k = 0; k < 6; k++) slot(k, pat_q[k], dp_q[k], 0, 7'h00);
  endtask

  task automatic set_frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                           input logic [6:0] p3, input logic [6:0] p4, input logic [6:0] p5);
    pat_q[0] = p0; pat_q[1] = p1; pat_q[2] = p2;
    pat_q[3] = p3; pat_q[4] = p4; pat_q[5] = p5;
    for (int k = 0; k < 6; k++) dp_q[k] = 1'b0;
  endtask

  initial begin
    int f0;
    for (int k = 0; k < 6; k++) begin
      m_seg[k] = '0;
      m_dp[k]  = 1'b0;
    end

    wait_cyc(3);
    check_all("reset");
    chk_vec("reset scan_err", 64'(scan_err), 64'(0));
    chk_vec("reset bad_code", 64'(bad_code), 64'(0));
    rst_n = 1'b1;
    wait_cyc(2);

    // 12:34 with two blank leading digits
    set_frame(7'h33, 7'h79, 7'h6D, 7'h30, 7'h00, 7'h00);
    scan();
    chk_int("t1 latency", last_frame_cyc - drv_cyc, 2 + SETTLE + 2);
    chk_vec("t1 bcd", 64'(digit_bcd), 64'h00FF1234);
    chk_vec("t1 dp", 64'(dpo), 64'h0);
    scan();
    chk_int("t1 frame count", frames, 2);

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 6; k++) begin
        int r;
        r = $urandom_range(0, 11);
        if (r < 10)       pat_q[k] = seg_tbl[r];
        else if (r == 10) pat_q[k] = 7'h00;
        else              pat_q[k] = 7'($urandom_range(0, 127));
        dp_q[k] = 1'($urandom_range(0, 1));
      end
      scan();
    end

    // slot 2 pattern moves shortly after its enable falls
    set_frame(7'h7E, 7'h30, 7'h5B, 7'h79, 7'h33, 7'h70);
    f0 = errs_seen;
    slot(0, pat_q[0], 1'b0, 0, 7'h00);
    slot(1, pat_q[1], 1'b0, 0, 7'h00);
    slot(2, 7'h5B, 1'b1, 3, 7'h7F);
    slot(3, pat_q[3], 1'b0, 0, 7'h00);
    slot(4, pat_q[4], 1'b0, 0, 7'h00);
    slot(5, pat_q[5], 1'b0, 0, 7'h00);
    chk_vec("t2 slot2 bcd", 64'(digit_bcd[11:8]), 64'h5);
    chk_int("t2 no err", errs_seen, f0);

    set_frame(7'h7E, 7'h30, 7'h55, 7'h79, 7'h33, 7'h70);
    f0 = bads_seen;
    scan();
    chk_int("t3 bad pulse", bads_seen, f0 + 1);
    chk_vec("t3 bcd slot2", 64'(digit_bcd[11:8]), 64'hE);
    chk_vec("t3 seg slot2", 64'(digit_seg[20:14]), 64'h55);

    // out-of-order slot 3
    set_frame(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F);
    f0 = frames;
    slot(0, pat_q[0], 1'b0, 0, 7'h00);
    slot(1, pat_q[1], 1'b0, 0, 7'h00);
    slot(3, pat_q[3], 1'b0, 0, 7'h00);
    chk_int("t4 err at 3", errs_seen, exp_errs);
    slot(4, pat_q[4], 1'b0, 0, 7'h00);
    slot(5, pat_q[5], 1'b0, 0, 7'h00);
    slot(0, pat_q[0], 1'b0, 0, 7'h00);
    slot(1, pat_q[1], 1'b0, 0, 7'h00);
    chk_int("t4 no early frame", frames, f0);
    slot(2, pat_q[2], 1'b0, 0, 7'h00);
    chk_int("t4 frame after 2", frames, f0 + 1);

    enb = 6'b111100;
    wait_cyc(20);
    exp_errs++;
    check_all("t5 multi");
    enb = '1;
    wait_cyc(TIMEOUT + 10);
    exp_lost = 1'b1;
    m_mask   = '0;
    m_free   = 1'b1;
    check_all("t5 lost");
    set_frame(7'h7F, 7'h73, 7'h00, 7'h7E, 7'h30, 7'h6D);
    scan();
    chk_vec("t5 lost at frame", 64'(lost_at_frame), 64'h0);

    set_frame(7'h5F, 7'h70, 7'h7F, 7'h73, 7'h33, 7'h5B);
    for (int k = 0; k < 4; k++) slot(k, pat_q[k], 1'b1, 0, 7'h00);
    f0    = frames;
    rst_n = 1'b0;
    enb   = '1;
    seg   = '0;
    dp    = 1'b0;
    wait_cyc(1);
    chk_vec("t6 seg", 64'(digit_seg), 64'h0);
    chk_vec("t6 bcd", 64'(digit_bcd), 64'h0);
    chk_vec("t6 dp", 64'(dpo), 64'h0);
    chk_vec("t6 frame_vld", 64'(frame_vld), 64'h0);
    chk_vec("t6 lost", 64'(lost), 64'h0);
    rst_n    = 1'b1;
    exp_seg  = '0;
    exp_bcd  = '0;
    exp_dp   = '0;
    exp_lost = 1'b0;
    m_mask   = '0;
    m_free   = 1'b1;
    wait_cyc(2);
    chk_int("t6 no frame", frames, f0);
    scan();
    chk_int("t6 first frame", frames, f0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
